// File: rtl/sequence_detector_n.sv
// Serial pattern detector with a runtime-loadable pattern/length and overlap mode.
// Registered match pulse one clock after the completing bit. The block has no backpressure.
module sequence_detector_n #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   localparam int LW     = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in,
   input  logic               in_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   output logic               out,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0]      len;
   logic               ovl;
   logic [MAX_LEN-1:0] hist;
   logic [LW-1:0]      fill;

   logic [MAX_LEN-1:0] hist_nxt;
   logic [LW-1:0]      fill_nxt;
   logic [MAX_LEN-1:0] len_mask;
   logic               hit;
   logic               cfg_legal;

   always_comb begin
      hist_nxt = {hist[MAX_LEN-2:0], in};
      fill_nxt = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
      len_mask = '0;
      // Only the low len bits take part in the compare.
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len));
      end
      hit       = (((hist_nxt ^ pat) & len_mask) == '0) && (fill_nxt >= len);
      cfg_legal = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat         <= MAX_LEN'(5);
         len         <= LW'(3);
         ovl         <= 1'b1;
         hist        <= '0;
         fill        <= '0;
         match_count <= '0;
         out         <= 1'b0;
         cfg_err     <= 1'b0;
      end else if (cfg_load) begin
         // A load always wins over a data bit, and the bit is dropped.
         out <= 1'b0;
         if (cfg_legal) begin
            pat     <= cfg_pattern;
            len     <= cfg_len;
            ovl     <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            cfg_err <= 1'b0;
         end else begin
            cfg_err <= 1'b1;
         end
      end else if (in_valid) begin
         cfg_err <= 1'b0;
         hist    <= hist_nxt;
         fill    <= (hit && !ovl) ? '0 : fill_nxt;
         out     <= hit;
         if (hit && !(&match_count)) begin
            match_count <= match_count + CNT_W'(1);
         end
      end else begin
         cfg_err <= 1'b0;
         out     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sequence_detector_n.sv
// Directed bench for sequence_detector_n; a second instance with CNT_W=2 shares the stimulus.
module tb_sequence_detector_n;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_bit;
   logic       in_valid;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       out_a, out_b;
   logic [7:0] count_a;
   logic [1:0] count_b;
   logic       err_a, err_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sequence_detector_n #(.MAX_LEN(8), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .out(out_a), .match_count(count_a), .cfg_err(err_a)
   );

   sequence_detector_n #(.MAX_LEN(8), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .out(out_b), .match_count(count_b), .cfg_err(err_b)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic exp_out, input string tag);
      in_valid = 1'b1;
      in_bit   = b;
      tick();
      in_valid = 1'b0;
      check({tag, " out_a"}, out_a, exp_out);
      check({tag, " out_b"}, out_b, exp_out);
   endtask

   task automatic idle(input string tag);
      in_valid = 1'b0;
      tick();
      check({tag, " idle out"}, out_a, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                       input logic with_bit, input logic exp_err, input string tag);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      in_valid    = with_bit;
      in_bit      = 1'b1;
      tick();
      cfg_load = 1'b0;
      in_valid = 1'b0;
      check({tag, " cfg_err"}, err_a, exp_err);
      check({tag, " out"}, out_a, 1'b0);
   endtask

   initial begin
      reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      // Reset also dominates simultaneous load and data.
      cfg_load = 1'b1; cfg_len = 4'd0; in_valid = 1'b1; in_bit = 1'b1;
      tick(); tick();
      cfg_load = 1'b0; in_valid = 1'b0;
      check("rst out", out_a, 1'b0);
      check("rst count", count_a, 8'd0);
      check("rst cfg_err", err_a, 1'b0);
      reset = 1'b0;

      // Default 101 overlapping on 1,0,1,0,1.
      send_bit(1, 0, "ovl b1"); send_bit(0, 0, "ovl b2"); send_bit(1, 1, "ovl b3");
      send_bit(0, 0, "ovl b4"); send_bit(1, 1, "ovl b5");
      check("ovl count", count_a, 8'd2);

      // Non-overlapping 101; the load leaves the count at 2.
      load(8'b0000_0101, 4'd3, 1'b0, 1'b0, 1'b0, "load nov");
      check("load keeps count", count_a, 8'd2);
      send_bit(1, 0, "nov b1"); send_bit(0, 0, "nov b2"); send_bit(1, 1, "nov b3");
      send_bit(0, 0, "nov b4"); send_bit(1, 0, "nov b5");
      check("nov count", count_a, 8'd3);

      // 1101 overlapping with an idle gap between bits 2 and 3.
      load(8'b0000_1101, 4'd4, 1'b1, 1'b0, 1'b0, "load 1101");
      send_bit(1, 0, "l4 b1"); send_bit(1, 0, "l4 b2");
      idle("l4");
      send_bit(0, 0, "l4 b3"); send_bit(1, 1, "l4 b4"); send_bit(1, 0, "l4 b5");
      send_bit(0, 0, "l4 b6"); send_bit(1, 1, "l4 b7");
      check("l4 count", count_a, 8'd5);

      // Illegal loads keep partial history and drop the concurrent bit.
      do_reset();
      send_bit(1, 0, "ill b1"); send_bit(0, 0, "ill b2");
      load(8'hFF, 4'd0, 1'b0, 1'b1, 1'b1, "ill len0");
      load(8'hFF, 4'd9, 1'b0, 1'b0, 1'b1, "ill len9");
      idle("ill");
      check("ill err clears", err_a, 1'b0);
      send_bit(1, 1, "ill b3");
      check("ill count", count_a, 8'd1);

      // Legal load clears history; bits above len are ignored.
      send_bit(1, 0, "clr pre1"); send_bit(0, 0, "clr pre2");
      load(8'hF5, 4'd3, 1'b1, 1'b1, 1'b0, "load F5");
      send_bit(1, 0, "clr b1"); send_bit(0, 0, "clr b2"); send_bit(1, 1, "clr b3");
      check("clr count", count_a, 8'd2);

      // Five overlapping matches: 8-bit counter reaches 5, 2-bit counter holds at 3.
      do_reset();
      for (int i = 1; i <= 11; i++) begin
         send_bit(i % 2, (i >= 3) && (i % 2 == 1), $sformatf("sat b%0d", i));
         if (i == 7) check("sat count_b at 3rd", count_b, 2'd3);
      end
      check("sat count_a", count_a, 8'd5);
      check("sat count_b", count_b, 2'd3);

      // Reset mid-sequence discards history.
      do_reset();
      send_bit(1, 0, "mid b1"); send_bit(0, 0, "mid b2");
      do_reset();
      check("mid rst out", out_a, 1'b0);
      send_bit(1, 0, "mid b3");
      check("mid count", count_a, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sequence_detector_n.md
SEQUENCE_DETECTOR_N -- requirements
Module: sequence_detector_n

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits; legal range is 2..16.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the match counter.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in, input, 1: serial data bit.
REQ-006 Port in_valid, input, 1: when high, `in` SHALL be consumed that cycle.
REQ-007 Port cfg_load, input, 1: when high, the configuration inputs SHALL be loaded that cycle.
REQ-008 Port cfg_pattern, input, MAX_LEN: pattern bits; bit [len-1] is the first bit received, bit 0 the last.
REQ-009 Port cfg_len, input, $clog2(MAX_LEN+1): pattern length.
REQ-010 Port cfg_overlap, input, 1: 1 selects overlapping detection, 0 selects non-overlapping.
REQ-011 Port out, output, 1: registered one-cycle match pulse.
REQ-012 Port match_count, output, CNT_W: number of matches, saturating.
REQ-013 Port cfg_err, output, 1: registered one-cycle pulse on an illegal configuration load.

Function
REQ-014 Active configuration registers (pat, len, ovl) SHALL hold the values used for detection.
REQ-015 On an accepted bit, history SHALL shift as hist <= {hist[MAX_LEN-2:0], in}.
REQ-016 On an accepted bit, fill counter `fill` SHALL increment, saturating at MAX_LEN.
REQ-017 A match SHALL occur on an accepted bit when the post-shift hist[len-1:0] equals pat[len-1:0] and the post-increment fill >= len.
REQ-018 `out` SHALL be 1 exactly in the cycle after the accepted bit that completes a match, and 0 otherwise; latency is 1 clock.
REQ-019 If in_valid is 0, the block SHALL leave hist, fill and match_count unchanged and SHALL drive out=0 in the next cycle.
REQ-020 When ovl=1, hist and fill SHALL continue unchanged after a match, so overlapping matches are detected (e.g. 101 in stream 10101 gives 2 matches).
REQ-021 When ovl=0, a match SHALL clear fill to 0, so the next match requires len fresh accepted bits.
REQ-022 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-023 A legal cfg_load (1 <= cfg_len <= MAX_LEN) SHALL latch pat, len and ovl, and clear hist, fill and out.
REQ-024 A legal cfg_load SHALL leave match_count unchanged.
REQ-025 An illegal cfg_load (cfg_len=0 or cfg_len>MAX_LEN) SHALL leave all configuration and detection state unchanged and pulse cfg_err=1 in the next cycle.
REQ-026 If cfg_load and in_valid are both high, the cfg_load SHALL take priority and `in` SHALL be discarded; this holds even when the load is illegal.
REQ-027 Pattern bits above len-1 SHALL be ignored in the compare.

Reset
REQ-028 When reset is high at a clock edge, the block SHALL set pat=101 (zero-extended), len=3 and ovl=1.
REQ-029 When reset is high at a clock edge, the block SHALL clear hist, fill and match_count to 0, and drive out=0 and cfg_err=0.
REQ-030 Reset SHALL take priority over cfg_load and in_valid.
REQ-031 A reset asserted mid-sequence SHALL discard all partial history.

Verification
REQ-032 After reset with defaults (101, overlap), accept 1,0,1,0,1 on consecutive cycles -> out pulses the cycle after bits 3 and 5; match_count=2.
REQ-033 Load pat=101, len=3, ovl=0, then accept 1,0,1,0,1 -> a single out pulse after bit 3; match_count=1.
REQ-034 Load pat=1101, len=4, ovl=1, then accept 1,1,0,1,1,0,1 with one in_valid=0 idle cycle between bits 2 and 3 -> out pulses after bits 4 and 7 only; no pulse during the idle cycle.
REQ-035 Load cfg_len=0 -> cfg_err pulses 1 cycle; stream 1,0,1 still matches 101 -> out=1 once.
REQ-036 With CNT_W=2 and defaults, accept 1,0,1,0,1,0,1,0,1,0,1 (5 matches) -> match_count stays 3 after the third match; out still pulses 5 times.
REQ-037 Accept 1,0, assert reset for 1 cycle, then accept 1 -> no out pulse; match_count=0.
